// File: rtl/uba_intr_arb.sv
// uba_intr_arb: Unibus adapter interrupt arbiter and vector-read sequencer.
// Maps device BR levels onto programmed KS10 PI levels and runs the IACK handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   devIRQ  [N]           per-device interrupt request (level)
//   devBR   [2*N]         per-device BR level (3=BR7 .. 0=BR4)
//   devVECT [VW*N]        per-device interrupt vector
//   ubaPIH, ubaPIL [3]    PI level for BR7/BR6 and BR5/BR4 (0 = disabled)
//   ackREQ, ackPI [3]     CPU vector-read request and level acknowledged
//   piREQ   [7]           PI request to CPU, bit k-1 = level k
//   ackVALID, ackVECT     vector response (vector 0 = passive release)
//   devIACK [N]           one-hot single-cycle acknowledge to the winning device
module uba_intr_arb #(
    parameter int N  = 4,
    parameter int VW = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    devIRQ,
    input  logic [2*N-1:0]  devBR,
    input  logic [VW*N-1:0] devVECT,
    input  logic [2:0]      ubaPIH,
    input  logic [2:0]      ubaPIL,
    input  logic            ackREQ,
    input  logic [2:0]      ackPI,
    output logic [6:0]      piREQ,
    output logic            ackVALID,
    output logic [VW-1:0]   ackVECT,
    output logic [N-1:0]    devIACK
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SNAP,
        S_SEL,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    cand_q, cand_d;
    logic [6:0]      pi_q, pi_d;
    logic            valid_q, valid_d;
    logic [VW-1:0]   vect_q, vect_d;
    logic [N-1:0]    iack_q, iack_d;

    logic            hi_req;
    logic            lo_req;
    logic [N-1:0]    match;
    logic            win_found;
    logic [1:0]      win_br;
    logic [N-1:0]    win_oh;
    logic [VW-1:0]   win_vect;

    // BR7/BR6 form the high group (BR msb set), BR5/BR4 the low group.
    always_comb begin
        hi_req = 1'b0;
        lo_req = 1'b0;
        match  = '0;
        for (int i = 0; i < N; i++) begin
            if (devIRQ[i]) begin
                if (devBR[2*i+1]) hi_req = 1'b1;
                else              lo_req = 1'b1;
            end
            if (devBR[2*i+1])
                match[i] = devIRQ[i] && (ubaPIH != 3'd0) && (ackPI == ubaPIH);
            else
                match[i] = devIRQ[i] && (ubaPIL != 3'd0) && (ackPI == ubaPIL);
        end
        pi_d = '0;
        for (int k = 1; k <= 7; k++) begin
            if ((hi_req && ubaPIH == 3'(k)) || (lo_req && ubaPIL == 3'(k)))
                pi_d[k-1] = 1'b1;
        end
    end

    // Strict '>' keeps the lowest index among equal BR levels.
    always_comb begin
        win_found = 1'b0;
        win_br    = 2'd0;
        win_oh    = '0;
        win_vect  = '0;
        for (int i = 0; i < N; i++) begin
            if (cand_q[i] && (!win_found || devBR[2*i +: 2] > win_br)) begin
                win_found = 1'b1;
                win_br    = devBR[2*i +: 2];
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_vect  = devVECT[VW*i +: VW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        valid_d = valid_q;
        vect_d  = vect_q;
        iack_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (ackREQ) state_d = S_SNAP;
            end
            S_SNAP: begin
                cand_d  = match;
                state_d = S_SEL;
            end
            S_SEL: begin
                // An empty candidate set yields vector 0 and no IACK.
                valid_d = 1'b1;
                vect_d  = win_vect;
                iack_d  = win_oh;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (!ackREQ) begin
                    valid_d = 1'b0;
                    vect_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            pi_q    <= '0;
            valid_q <= 1'b0;
            vect_q  <= '0;
            iack_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            pi_q    <= pi_d;
            valid_q <= valid_d;
            vect_q  <= vect_d;
            iack_q  <= iack_d;
        end
    end

    assign piREQ    = pi_q;
    assign ackVALID = valid_q;
    assign ackVECT  = vect_q;
    assign devIACK  = iack_q;

endmodule
